// File: rtl/spi_master_ctrl_pkg.sv
// rtl/spi_master_ctrl_pkg.sv - state encodings and SPI mode constants for the SPI master
package spi_master_ctrl_pkg;

  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_GAP   = 3'd3,
    S_END   = 3'd4
  } state_t;

  // sclk level just after the edge on which miso is sampled
  function automatic logic sample_level(input logic cpol, input logic cpha);
    return ~(cpol ^ cpha);
  endfunction

endpackage

// File: rtl/spi_master_ctrl_if.sv
// rtl/spi_master_ctrl_if.sv - parallel tx/rx word handshake between a client and the SPI master
interface spi_master_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] tx_data;
  logic             tx_last;
  logic             rx_valid;
  logic [WIDTH-1:0] rx_data;

  modport master (
    output tx_valid, tx_data, tx_last,
    input  tx_ready, rx_valid, rx_data
  );

  modport slave (
    input  tx_valid, tx_data, tx_last,
    output tx_ready, rx_valid, rx_data
  );
endinterface

// File: rtl/spi_shift_reg.sv
// rtl/spi_shift_reg.sv - full-duplex shift register: parallel load, MSB out, LSB in
module spi_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             shift_in,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      data <= '0;
    end else if (load) begin
      data <= load_data;
    end else if (shift_en) begin
      data <= {data[WIDTH-2:0], shift_in};
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI mode-0 master sequencer with word handshake and multi-word frames
module spi_master_ctrl
  import spi_master_ctrl_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rstn,
  spi_master_ctrl_if.slave  bus,
  output logic              busy,
  output logic              cs_n,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);

  localparam int              BW         = $clog2(WIDTH + 1);
  localparam int              DW         = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0]   DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0]   BIT_LAST   = BW'(WIDTH);
  localparam logic            SAMPLE_LVL = sample_level(SPI_CPOL, SPI_CPHA);

  state_t           state;
  logic [DW-1:0]    div_cnt;
  logic [BW-1:0]    bit_cnt;
  logic             last_q;
  logic [WIDTH-1:0] sr_q;
  logic             accept;
  logic             tick;
  logic             sample_edge;

  assign accept      = bus.tx_valid & bus.tx_ready;
  assign tick        = (div_cnt == DIV_LAST);
  // The first sampling edge leaves SETUP; later ones come from SHIFT.
  assign sample_edge = tick && ((state == S_SETUP) || (state == S_SHIFT)) && (~sclk == SAMPLE_LVL);

  spi_shift_reg #(.WIDTH(WIDTH)) u_shift (
    .clk       (clk),
    .rstn      (rstn),
    .load      (accept),
    .load_data (bus.tx_data),
    .shift_en  (sample_edge),
    .shift_in  (miso),
    .data      (sr_q)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= S_IDLE;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      last_q       <= 1'b0;
      cs_n         <= 1'b1;
      sclk         <= SPI_CPOL;
      mosi         <= 1'b0;
      busy         <= 1'b0;
      bus.tx_ready <= 1'b1;
      bus.rx_valid <= 1'b0;
      bus.rx_data  <= '0;
    end else begin
      bus.rx_valid <= 1'b0;
      case (state)
        S_IDLE, S_GAP: begin
          if (accept) begin
            state        <= S_SETUP;
            last_q       <= bus.tx_last;
            cs_n         <= 1'b0;
            mosi         <= bus.tx_data[WIDTH-1];
            busy         <= 1'b1;
            bus.tx_ready <= 1'b0;
            div_cnt      <= '0;
            bit_cnt      <= '0;
          end
        end
        S_SETUP: begin
          if (tick) begin
            state   <= S_SHIFT;
            sclk    <= ~sclk;
            bit_cnt <= bit_cnt + BW'(1);
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        S_SHIFT: begin
          if (tick) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
            if (sample_edge) begin
              bit_cnt <= bit_cnt + BW'(1);
            end else if (bit_cnt == BIT_LAST) begin
              // Word complete: mosi keeps its final bit, sr_q already holds all miso bits.
              bus.rx_valid <= 1'b1;
              bus.rx_data  <= sr_q;
              bit_cnt      <= '0;
              bus.tx_ready <= ~last_q;
              state        <= last_q ? S_END : S_GAP;
            end else begin
              mosi <= sr_q[WIDTH-1];
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        S_END: begin
          if (tick) begin
            state        <= S_IDLE;
            cs_n         <= 1'b1;
            busy         <= 1'b0;
            bus.tx_ready <= 1'b1;
            div_cnt      <= '0;
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
